// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 slave memory.
package apb4_pkg;

  // Transfer state: IDLE waits for a setup phase, ACCESS holds a captured transfer.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb4_state_e;

  // Number of byte-offset address bits inside one bus word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb4_byte_ram.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// Reset clears every word and the read register.
module apb4_byte_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; async reset zeroes the whole array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read; the output is zero whenever no read is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 slave backed by a byte-writable word memory, with programmable
// wait states and a saturating error counter.
//
// Handshake: a transfer starts with a setup phase (psel=1, penable=0) sampled
// in IDLE; the bus then holds psel=1, penable=1 and the transfer completes at
// the first edge that also sees pready=1. Dropping psel or penable while in
// ACCESS abandons the transfer. pready/pslverr/prdata come straight from flops.
module apb4_slave_mem
  import apb4_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [7:0]          err_cnt,
  output apb4_state_e         state_dbg
);

  localparam int         LANE   = lane_bits(DATA_W);
  localparam int         NB     = DATA_W / 8;
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT_STATES);

  // Out-of-range word index or a byte offset inside the word is an error.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [31:0]       idx;
    logic [ADDR_W-1:0] mask;
    idx  = 32'(a >> LANE);
    mask = ADDR_W'((1 << LANE) - 1);
    return (idx >= 32'(DEPTH)) || ((a & mask) != '0);
  endfunction

  apb4_state_e       state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              pready_n, pslverr_n;
  logic              load, done;
  logic              rd_en;
  logic [NB-1:0]     wr_be;
  logic [AW-1:0]     rd_addr;

  logic [AW-1:0]     cap_idx;
  logic              cap_write;
  logic              cap_err;
  logic [DATA_W-1:0] cap_wdata;
  logic [NB-1:0]     cap_strb;

  logic              setup, access_ok, in_err;

  assign setup     = psel & ~penable;
  assign access_ok = psel & penable;
  assign in_err    = addr_err(paddr);
  assign state_dbg = state;

  // Next-state, handshake and memory-control decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    wr_be     = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_n = ACCESS;
          cnt_n   = 4'd0;
          load    = 1'b1;
          if (WAIT_L == 4'd0) begin
            pready_n  = 1'b1;
            pslverr_n = in_err;
            rd_en     = ~pwrite & ~in_err;
          end
        end
      end
      ACCESS: begin
        if (!access_ok) begin
          state_n = IDLE;
        end else if (pready) begin
          state_n = IDLE;
          done    = 1'b1;
          if (cap_write && !cap_err) wr_be = cap_strb;
        end else begin
          cnt_n = cnt + 4'd1;
          if (cnt_n == WAIT_L) begin
            pready_n  = 1'b1;
            pslverr_n = cap_err;
            rd_en     = ~cap_write & ~cap_err;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, wait counter and registered handshake outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
    end
  end

  // Capture the transfer attributes at the setup edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (load) begin
      cap_idx   <= AW'(paddr >> LANE);
      cap_write <= pwrite;
      cap_err   <= in_err;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
    end
  end

  // Count errored completions, holding at 255.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                                     err_cnt <= 8'd0;
    else if (done && cap_err && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
  end

  // The read is launched at the edge that raises pready, so the word must be
  // addressed from paddr itself when there are no wait states.
  assign rd_addr = (state == IDLE) ? AW'(paddr >> LANE) : cap_idx;

  apb4_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (pclk),
    .rst     (preset),
    .wr_be   (wr_be),
    .wr_addr (cap_idx),
    .wr_data (cap_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (prdata)
  );

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Directed bench for apb4_slave_mem: one instance with no wait states and one
// with three, sharing every bus signal except psel.
module tb_apb4_slave_mem;
  import apb4_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel0, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [7:0]  err_cnt0, err_cnt3;
  apb4_state_e state0, state3;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_v;
  logic        er_v;
  int          cy_v;

  // Clock.
  always #5 pclk = ~pclk;

  apb4_slave_mem #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .err_cnt(err_cnt0), .state_dbg(state0)
  );

  apb4_slave_mem #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .err_cnt(err_cnt3), .state_dbg(state3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer: setup, access, wait for pready (bounded), complete.
  // Leaves psel low right after the completion edge, so a following call
  // issues its setup on the very next cycle.
  task automatic xfer(input int which, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic move,
                      output logic [31:0] rdata, output logic err, output int cycles);
    logic got;
    got = 1'b0; cycles = 0; rdata = '0; err = 1'b0;
    if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1 penable = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      cycles++;
      if ((which == 0) ? pready0 : pready3) begin
        got   = 1'b1;
        rdata = (which == 0) ? prdata0 : prdata3;
        err   = (which == 0) ? pslverr0 : pslverr3;
      end else begin
        if (move) begin
          paddr = a ^ 12'h004; pwdata = ~d; pwrite = ~wr; pstrb = ~s;
        end
        @(posedge pclk); #1;
      end
    end
    chk("pready_timeout", 64'(got), 64'd1);
    if (got) begin @(posedge pclk); #1; end
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input string tag, input int which, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic exp_err, input int exp_cycles);
    xfer(which, 1'b1, a, d, s, 1'b0, rd_v, er_v, cy_v);
    chk({tag, "_err"}, 64'(er_v), 64'(exp_err));
    chk({tag, "_cycles"}, 64'(cy_v), 64'(exp_cycles));
  endtask

  task automatic do_read(input string tag, input int which, input logic [11:0] a,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_cycles, input logic move);
    xfer(which, 1'b0, a, 32'h0, 4'h0, move, rd_v, er_v, cy_v);
    chk({tag, "_data"}, 64'(rd_v), 64'(exp_data));
    chk({tag, "_err"}, 64'(er_v), 64'(exp_err));
    chk({tag, "_cycles"}, 64'(cy_v), 64'(exp_cycles));
  endtask

  initial begin
    // Reset.
    preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_state", 64'(state0), 64'(IDLE));
    chk("rst_pready", 64'(pready0), 64'd0);
    chk("rst_pslverr", 64'(pslverr0), 64'd0);
    chk("rst_prdata", 64'(prdata0), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt0), 64'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Full-word write then read, no wait states.
    do_write("wr_full", 0, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1);
    do_read("rd_full", 0, 12'h010, 32'hDEADBEEF, 1'b0, 1, 1'b0);
    @(negedge pclk);
    chk("prdata_idle", 64'(prdata0), 64'd0);
    chk("pready_idle", 64'(pready0), 64'd0);

    // Partial byte strobes, back-to-back with the read.
    do_write("wr_strb5", 0, 12'h010, 32'h11223344, 4'h5, 1'b0, 1);
    do_read("rd_strb5", 0, 12'h010, 32'hDE22BE44, 1'b0, 1, 1'b0);

    // Zero strobes write nothing and are not errors.
    do_write("wr_strb0", 0, 12'h010, 32'hFFFFFFFF, 4'h0, 1'b0, 1);
    do_read("rd_strb0", 0, 12'h010, 32'hDE22BE44, 1'b0, 1, 1'b0);

    // Errors: out-of-range write (index 64 aliases word 0 if truncated) and misaligned read.
    do_write("wr_oor", 0, 12'h100, 32'h55AA55AA, 4'hF, 1'b1, 1);
    do_read("rd_mis", 0, 12'h013, 32'h0, 1'b1, 1, 1'b0);
    @(negedge pclk);
    chk("err_cnt_2", 64'(err_cnt0), 64'd2);
    do_read("rd_w0", 0, 12'h000, 32'h0, 1'b0, 1, 1'b0);
    do_read("rd_keep", 0, 12'h010, 32'hDE22BE44, 1'b0, 1, 1'b0);

    // Access phase without setup is ignored.
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("nosetup_state", 64'(state0), 64'(IDLE));
    chk("nosetup_pready", 64'(pready0), 64'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    do_read("rd_nosetup", 0, 12'h010, 32'hDE22BE44, 1'b0, 1, 1'b0);

    // Three wait states; address/data/direction changes during wait are ignored.
    do_write("w3_a", 1, 12'h010, 32'hAABBCCDD, 4'hF, 1'b0, 4);
    do_write("w3_b", 1, 12'h014, 32'h01020304, 4'hF, 1'b0, 4);
    do_read("r3_move", 1, 12'h010, 32'hAABBCCDD, 1'b0, 4, 1'b1);
    do_read("r3_b", 1, 12'h014, 32'h01020304, 1'b0, 4, 1'b0);

    // Abort: psel dropped during the wait, then the word must stay untouched.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h11111111; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort_state", 64'(state3), 64'(IDLE));
    chk("abort_pready", 64'(pready3), 64'd0);
    do_read("rd_abort", 1, 12'h020, 32'h0, 1'b0, 4, 1'b0);
    chk("abort_err_cnt", 64'(err_cnt3), 64'd0);

    // Saturation of err_cnt at 255.
    for (int i = 0; i < 253; i++) xfer(0, 1'b1, 12'h101, 32'h0, 4'hF, 1'b0, rd_v, er_v, cy_v);
    @(negedge pclk);
    chk("err_cnt_255", 64'(err_cnt0), 64'd255);
    do_write("wr_sat", 0, 12'h200, 32'h0, 4'hF, 1'b1, 1);
    @(negedge pclk);
    chk("err_cnt_hold", 64'(err_cnt0), 64'd255);

    // Reset pulsed during the wait of a write to 0x020.
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #2 preset = 1'b1;
    #1;
    chk("mid_rst_state", 64'(state3), 64'(IDLE));
    chk("mid_rst_pready", 64'(pready3), 64'd0);
    chk("mid_rst_prdata", 64'(prdata3), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt0), 64'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk) preset = 1'b0;
    @(posedge pclk); #1;
    do_read("rd_after_rst", 1, 12'h020, 32'h0, 1'b0, 4, 1'b0);
    do_read("rd_cleared", 0, 12'h010, 32'h0, 1'b0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_slave_mem.md
APB4_SLAVE_MEM -- requirements
Module: apb4_slave_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width; legal values 8/16/32/64.
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_W words of storage; 1..2**(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra access cycles before pready; 0..15.
REQ-005 pclk  in  1  clock; all flops on rising edge.
REQ-006 preset  in  1  reset, asynchronous, active-high.
REQ-007 psel  in  1  slave select.
REQ-008 penable  in  1  access phase strobe.
REQ-009 pwrite  in  1  1=write, 0=read.
REQ-010 paddr  in  ADDR_W  byte address.
REQ-011 pwdata  in  DATA_W  write data.
REQ-012 pstrb  in  DATA_W/8  write byte strobes.
REQ-013 prdata  out  DATA_W  read data.
REQ-014 pready  out  1  transfer complete.
REQ-015 pslverr  out  1  transfer error, valid only with pready.
REQ-016 err_cnt  out  8  saturating count of errored transfers.

Function
REQ-017 SHALL use FSM states IDLE and ACCESS; reset state IDLE.
REQ-018 IDLE -> ACCESS at an edge sampling psel=1, penable=0 (setup); SHALL capture paddr, pwrite, pwdata, pstrb and clear wait counter at that edge.
REQ-019 In ACCESS, wait counter SHALL increment each cycle until it equals WAIT_STATES; pready SHALL be 1 exactly when state=ACCESS and counter=WAIT_STATES (WAIT_STATES=0 -> pready in first access cycle).
REQ-020 pready, pslverr, prdata SHALL be driven from flops only; no combinational path from inputs.
REQ-021 ACCESS -> IDLE at the edge where psel=1, penable=1, pready=1; transfer completes there.
REQ-022 Word index = captured paddr >> log2(DATA_W/8).
REQ-023 pslverr SHALL be 1 with pready when word index >= DEPTH or captured paddr low log2(DATA_W/8) bits are nonzero; else 0.
REQ-024 Write completion without error SHALL update only bytes with pstrb[i]=1; pstrb=0 writes nothing and is not an error.
REQ-025 Errored writes SHALL not modify storage; errored reads SHALL return prdata=0.
REQ-026 prdata SHALL equal stored word while pready=1 on a non-errored read, and 0 at all other times.
REQ-027 Setup followed by psel=1 penable=0 in ACCESS, or psel=0 in ACCESS (abort), SHALL return to IDLE next edge with no storage update, no pready, no err_cnt change.
REQ-028 psel=1 penable=1 while IDLE (missing setup) SHALL be ignored; state stays IDLE.
REQ-029 Input changes during ACCESS SHALL be ignored; captured values are used.
REQ-030 Back-to-back: setup on the cycle after completion SHALL be accepted with no idle gap required.
REQ-031 err_cnt SHALL increment on each errored completion, saturating at 255.

Reset
REQ-032 preset=1 SHALL asynchronously force state IDLE, counter 0, pready 0, pslverr 0, prdata 0, err_cnt 0, all storage words 0.
REQ-033 Reset mid-ACCESS SHALL abandon the transfer with no storage write; first transfer after release needs a fresh setup.

Structure
REQ-034 Package apb4_pkg SHALL hold the FSM state enum and the log2 byte-lane helper constant function.
REQ-035 Storage SHALL be sub-module apb4_byte_ram (DEPTH x DATA_W, per-byte write enable, async-reset clear, registered read).

Verification
REQ-036 Defaults: write 0x0000_0010 data 0xDEADBEEF pstrb 0xF, read 0x010 -> prdata 0xDEADBEEF, pslverr 0, pready in first access cycle.
REQ-037 Write 0x010 data 0x11223344 pstrb 0x5 over 0xDEADBEEF, read -> 0xDE22BE44.
REQ-038 WAIT_STATES=3: read -> pready rises on 4th access cycle, low for first 3; paddr change during wait ignored.
REQ-039 Write 0x100 (index 64 >= DEPTH) and read 0x013 (misaligned) -> pslverr 1 with pready each, storage unchanged, prdata 0, err_cnt 2.
REQ-040 preset pulsed during wait of a write to 0x020 -> outputs 0, word 8 reads 0 after re-setup; psel dropped mid-access -> IDLE, no write.
